// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core.
package mips_pipe_pkg;

    // Occupancy of a stage register (number of entries currently held)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // Control word with every control line deasserted; stages drive it as a bubble
    localparam logic [7:0] NOP_CTRL = 8'h00;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall/bubble performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_count;

    // Count up on inc, stick at all-ones, clear on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush, and saturating stall/bubble counters.
//
// Handshake: an entry moves across a port on every rising edge where both
// valid and ready are high (accept upstream, retire downstream). Valid never
// depends on ready; payload is held stable while valid=1 and ready=0. Flush
// discards everything held and any accept in the same cycle.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter bit                 SKID_EN     = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_out_valid;
    logic              w_in_ready;
    logic [DATA_W-1:0] w_head_data;
    logic [CTRL_W-1:0] w_head_ctrl;
    logic              w_acc;
    logic              w_ret;

    assign w_acc = in_valid & w_in_ready;
    assign w_ret = w_out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            occ_state_t        r_state;
            occ_state_t        w_state_nxt;
            logic              r_in_rdy;
            logic [DATA_W-1:0] r_main_data, r_skid_data;
            logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
            logic              w_ld_main_in, w_ld_main_skid, w_ld_skid;

            // Next occupancy and which register loads what; flush overrides all
            always_comb begin
                w_state_nxt    = r_state;
                w_ld_main_in   = 1'b0;
                w_ld_main_skid = 1'b0;
                w_ld_skid      = 1'b0;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_acc) begin
                                w_state_nxt  = ST_ONE;
                                w_ld_main_in = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (w_acc && w_ret) begin
                                w_ld_main_in = 1'b1;
                            end else if (w_acc) begin
                                w_state_nxt = ST_FULL;
                                w_ld_skid   = 1'b1;
                            end else if (w_ret) begin
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (w_ret) begin
                                w_state_nxt    = ST_ONE;
                                w_ld_main_skid = 1'b1;
                            end
                        end
                        default: w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            // Occupancy register plus a registered copy of in_ready (no comb path)
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_state  <= ST_EMPTY;
                    r_in_rdy <= 1'b1;
                end else begin
                    r_state  <= w_state_nxt;
                    r_in_rdy <= (w_state_nxt != ST_FULL);
                end
            end

            // Payload registers: main is the head, skid holds the second entry
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_main_data <= '0;
                    r_main_ctrl <= '0;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end else begin
                    if (w_ld_main_in) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_ld_main_skid) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                    if (w_ld_skid) begin
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                    end
                end
            end

            assign w_out_valid = (r_state != ST_EMPTY);
            assign w_in_ready  = r_in_rdy;
            assign w_head_data = r_main_data;
            assign w_head_ctrl = r_main_ctrl;
        end else begin : g_single
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic [CTRL_W-1:0] r_ctrl;

            // Single entry; a simultaneous accept and retire reloads with no bubble
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_ctrl  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_acc) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                    r_ctrl  <= in_ctrl;
                end else if (w_ret) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_out_valid = r_valid;
            assign w_in_ready  = ~r_valid | out_ready;
            assign w_head_data = r_data;
            assign w_head_ctrl = r_ctrl;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_head_data : '0;
    assign out_ctrl  = w_out_valid ? w_head_ctrl : BUBBLE_CTRL;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~w_out_valid & out_ready),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (A) and one single-entry
// instance (B) share the same stimulus. A bounded-queue model per instance
// predicts every output each cycle; directed sections pin literal values.
module tb_pipe_stage_reg;

    localparam logic [7:0] BUB = 8'h5A;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [7:0]  a_out_ctrl, b_out_ctrl;
    logic [15:0] a_stall, a_bubble, b_stall, b_bubble;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .SKID_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .SKID_EN(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance is a FIFO of capacity 2 (A) or 1 (B); entry = {ctrl,data}
    logic [39:0] exp_q[2][$];
    int          stall_m[2];
    int          bub_m[2];

    logic        d_in_ready[2], d_out_valid[2];
    logic [31:0] d_out_data[2];
    logic [7:0]  d_out_ctrl[2];
    logic [15:0] d_stall[2], d_bubble[2];

    assign d_in_ready[0] = a_in_ready;   assign d_in_ready[1] = b_in_ready;
    assign d_out_valid[0] = a_out_valid; assign d_out_valid[1] = b_out_valid;
    assign d_out_data[0] = a_out_data;   assign d_out_data[1] = b_out_data;
    assign d_out_ctrl[0] = a_out_ctrl;   assign d_out_ctrl[1] = b_out_ctrl;
    assign d_stall[0] = a_stall;         assign d_stall[1] = b_stall;
    assign d_bubble[0] = a_bubble;       assign d_bubble[1] = b_bubble;

    function automatic logic model_ready(input int k);
        if (k == 0) return (exp_q[0].size() < 2);
        return (exp_q[1].size() == 0) || out_ready;
    endfunction

    // Compare process: advance the model at each edge, check outputs mid-cycle
    initial begin
        for (int k = 0; k < 2; k++) begin
            stall_m[k] = 0;
            bub_m[k]   = 0;
        end
        while (!done) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!reset) begin
                    exp_q[k].delete();
                    stall_m[k] = 0;
                    bub_m[k]   = 0;
                end else begin
                    logic has, acc, ret;
                    has = (exp_q[k].size() > 0);
                    acc = in_valid && model_ready(k);
                    ret = has && out_ready;
                    if (has && !out_ready && stall_m[k] < 65535) stall_m[k]++;
                    if (!has && out_ready && bub_m[k] < 65535) bub_m[k]++;
                    if (flush) begin
                        exp_q[k].delete();
                    end else begin
                        if (ret) void'(exp_q[k].pop_front());
                        if (acc) exp_q[k].push_back({in_ctrl, in_data});
                    end
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic        ev;
                logic [39:0] hd;
                ev = (exp_q[k].size() > 0);
                hd = ev ? exp_q[k][0] : {BUB, 32'h0};
                chk($sformatf("m%0d_out_valid", k), {31'b0, d_out_valid[k]}, {31'b0, ev});
                chk($sformatf("m%0d_out_data", k), d_out_data[k], hd[31:0]);
                chk($sformatf("m%0d_out_ctrl", k), {24'b0, d_out_ctrl[k]}, {24'b0, hd[39:32]});
                chk($sformatf("m%0d_in_ready", k), {31'b0, d_in_ready[k]}, {31'b0, model_ready(k)});
                chk($sformatf("m%0d_stall_cnt", k), {16'b0, d_stall[k]}, 32'(stall_m[k]));
                chk($sformatf("m%0d_bubble_cnt", k), {16'b0, d_bubble[k]}, 32'(bub_m[k]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[7:0] ^ 8'hC3;
    endtask

    initial begin
        // Reset with traffic offered: must be ignored
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        push(32'h99);
        cyc(); cyc();
        chk("rst_a_out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst_a_out_ctrl", {24'b0, a_out_ctrl}, {24'b0, BUB});
        chk("rst_a_out_data", a_out_data, 32'h0);
        chk("rst_a_stall", {16'b0, a_stall}, 32'd0);
        chk("rst_a_bubble", {16'b0, a_bubble}, 32'd0);
        chk("rst_a_in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("rst_b_out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("rst_b_out_ctrl", {24'b0, b_out_ctrl}, {24'b0, BUB});

        // Back-to-back stream, 1-cycle latency, no gaps
        reset = 1'b1; out_ready = 1'b1;
        push(32'h10); cyc();
        chk("str_a_10", a_out_data, 32'h10);
        chk("str_b_10", b_out_data, 32'h10);
        chk("str_a_bubble1", {16'b0, a_bubble}, 32'd1);
        push(32'h14); cyc();
        chk("str_a_14", a_out_data, 32'h14);
        chk("str_b_14", b_out_data, 32'h14);
        push(32'h18); cyc();
        chk("str_a_18", a_out_data, 32'h18);
        chk("str_a_ctrl18", {24'b0, a_out_ctrl}, 32'h18 ^ 32'hC3);
        in_valid = 1'b0; cyc();
        chk("str_a_drained", {31'b0, a_out_valid}, 32'd0);

        // Skid fill and drain in order
        out_ready = 1'b0;
        push(32'hA); cyc();
        push(32'hB); cyc();
        chk("skid_full_rdy", {31'b0, a_in_ready}, 32'd0);
        push(32'hC); cyc();
        chk("skid_hold_A", a_out_data, 32'hA);
        out_ready = 1'b1; cyc();
        chk("skid_out_B", a_out_data, 32'hB);
        cyc();
        chk("skid_out_C", a_out_data, 32'hC);
        in_valid = 1'b0; cyc();
        chk("skid_empty", {31'b0, a_out_valid}, 32'd0);

        // Flush while FULL with an offered entry
        out_ready = 1'b0;
        push(32'h1); cyc();
        push(32'h2); cyc();
        flush = 1'b1; push(32'hD); cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", {31'b0, a_out_valid}, 32'd0);
        chk("flush_full_rdy", {31'b0, a_in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_no_D", {31'b0, a_out_valid}, 32'd0);
        end
        // Flush while ONE: the same-cycle accept must be discarded
        out_ready = 1'b0;
        push(32'hE); cyc();
        flush = 1'b1; push(32'hD); cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_one_valid", {31'b0, a_out_valid}, 32'd0);
        chk("flush_one_b_valid", {31'b0, b_out_valid}, 32'd0);
        cyc();
        chk("flush_one_after", {31'b0, a_out_valid}, 32'd0);

        // Single-entry: accept and retire together, no bubble
        push(32'h20); cyc();
        out_ready = 1'b1; push(32'h24); #1;
        chk("single_rdy_comb", {31'b0, b_in_ready}, 32'd1);
        chk("single_head_20", b_out_data, 32'h20);
        cyc();
        chk("single_next_24", b_out_data, 32'h24);
        chk("single_valid", {31'b0, b_out_valid}, 32'd1);
        in_valid = 1'b0; cyc();

        // Randomised traffic including flush and reset
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom_range(0, 255));
            cyc();
        end

        // Stall counter saturation
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        push(32'h55); cyc();
        in_valid = 1'b0;
        repeat (65600) cyc();
        chk("sat_a_stall", {16'b0, a_stall}, 32'hFFFF);
        chk("sat_b_stall", {16'b0, b_stall}, 32'hFFFF);
        cyc();
        chk("sat_a_hold", {16'b0, a_stall}, 32'hFFFF);

        done = 1'b1;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time
    initial begin
        #(10 * 90000);
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
